// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART framing stage: FSM encoding and default
// frame parameters.
package uart_frame_pkg;

   typedef enum logic [2:0] {
      ST_HUNT = 3'd0,
      ST_LEN  = 3'd1,
      ST_DATA = 3'd2,
      ST_CHK  = 3'd3,
      ST_EMIT = 3'd4
   } state_t;

   localparam logic [7:0] DEF_SOF     = 8'h7E;
   localparam int         DEF_MAX_LEN = 16;
   localparam int         DEF_ADDR_W  = 4;

   // A length byte is legal when it is non-zero and fits the payload buffer.
   function automatic logic len_legal(input logic [7:0] b, input int max_len);
      return (b != 8'd0) && (int'(b) <= max_len);
   endfunction

endpackage

// File: rtl/uart_frame_rx_buf.sv
// Payload buffer: 2**ADDR_W bytes, synchronous write, asynchronous read.
module frame_buf #(
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [7:0]        wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [7:0]        rdata
);

   logic [7:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/uart_frame_rx.sv
// Frame receiver behind the UART RX FIFO: hunts SOF, collects a LEN-prefixed,
// XOR-checked payload and replays only good frames as a valid/ready stream.
module uart_frame_rx
   import uart_frame_pkg::*;
#(
   parameter int         MAX_LEN = DEF_MAX_LEN,
   parameter int         ADDR_W  = DEF_ADDR_W,
   parameter logic [7:0] SOF     = DEF_SOF,
   parameter int         TIMEOUT = 65535,
   parameter int         TO_W    = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_empty,
   input  logic [7:0] r_data,
   output logic       rd_uart,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic       out_last,
   output logic       frame_ok,
   output logic       err_len,
   output logic       err_chk,
   output logic       err_to,
   output logic       busy
);

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   state_t            state;
   logic [ADDR_W:0]   len;
   logic [ADDR_W:0]   cnt;
   logic [ADDR_W:0]   len_m1;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [7:0]        acc;
   logic [TO_W-1:0]   to_cnt;
   logic              in_frame;
   logic              pop;
   logic              to_expire;

   assign in_frame  = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CHK);
   assign pop       = ~rx_empty & (in_frame || (state == ST_HUNT));
   assign to_expire = in_frame & rx_empty & (to_cnt == TO_LAST);
   assign len_m1    = len - 1'b1;

   assign rd_uart   = pop;
   assign busy      = (state != ST_HUNT);
   assign out_valid = (state == ST_EMIT);
   assign out_last  = out_valid & ({1'b0, rd_ptr} == len_m1);

   frame_buf #(.ADDR_W(ADDR_W)) u_buf (
      .clk   (clk),
      .we    (pop & (state == ST_DATA)),
      .waddr (wr_ptr),
      .wdata (r_data),
      .raddr (rd_ptr),
      .rdata (out_data)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_HUNT;
         len      <= '0;
         cnt      <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         acc      <= '0;
         to_cnt   <= '0;
         frame_ok <= 1'b0;
         err_len  <= 1'b0;
         err_chk  <= 1'b0;
         err_to   <= 1'b0;
      end else begin
         frame_ok <= 1'b0;
         err_len  <= 1'b0;
         err_chk  <= 1'b0;
         err_to   <= 1'b0;

         // Idle counter only runs while a frame is open and the FIFO is dry.
         if (!in_frame || pop || to_expire) to_cnt <= '0;
         else                               to_cnt <= to_cnt + 1'b1;

         case (state)
            ST_HUNT: begin
               if (pop && (r_data == SOF)) state <= ST_LEN;
            end
            ST_LEN: begin
               if (pop) begin
                  if (!len_legal(r_data, MAX_LEN)) begin
                     err_len <= 1'b1;
                     state   <= ST_HUNT;
                  end else begin
                     len    <= r_data[ADDR_W:0];
                     acc    <= r_data;
                     wr_ptr <= '0;
                     cnt    <= '0;
                     state  <= ST_DATA;
                  end
               end else if (to_expire) begin
                  err_to <= 1'b1;
                  state  <= ST_HUNT;
               end
            end
            ST_DATA: begin
               // Byte count, not wr_ptr, ends the payload: wr_ptr wraps at MAX_LEN.
               if (pop) begin
                  wr_ptr <= wr_ptr + 1'b1;
                  acc    <= acc ^ r_data;
                  cnt    <= cnt + 1'b1;
                  if ((cnt + 1'b1) == len) state <= ST_CHK;
               end else if (to_expire) begin
                  err_to <= 1'b1;
                  state  <= ST_HUNT;
               end
            end
            ST_CHK: begin
               if (pop) begin
                  if (r_data == acc) begin
                     frame_ok <= 1'b1;
                     rd_ptr   <= '0;
                     state    <= ST_EMIT;
                  end else begin
                     err_chk <= 1'b1;
                     state   <= ST_HUNT;
                  end
               end else if (to_expire) begin
                  err_to <= 1'b1;
                  state  <= ST_HUNT;
               end
            end
            ST_EMIT: begin
               if (out_ready) begin
                  rd_ptr <= rd_ptr + 1'b1;
                  if (out_last) state <= ST_HUNT;
               end
            end
            default: state <= ST_HUNT;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Randomized bench for uart_frame_rx: a queue stands in for the RX FIFO and a
// byte-stream parser predicts frames, drops and replayed payload.
module tb_uart_frame_rx;

   localparam int         TB_TO   = 300;
   localparam int         MAXL    = 16;
   localparam logic [7:0] SOF_B   = 8'h7E;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx_empty;
   logic [7:0] r_data;
   logic       rd_uart;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_last;
   logic       frame_ok;
   logic       err_len;
   logic       err_chk;
   logic       err_to;
   logic       busy;

   uart_frame_rx #(.TIMEOUT(TB_TO)) dut (
      .clk       (clk),
      .reset     (reset),
      .rx_empty  (rx_empty),
      .r_data    (r_data),
      .rd_uart   (rd_uart),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .frame_ok  (frame_ok),
      .err_len   (err_len),
      .err_chk   (err_chk),
      .err_to    (err_to),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] stim[$];
   logic [7:0] fifo[$];
   logic [8:0] exp_q[$];
   logic [8:0] got_q[$];
   int e_ok, e_len, e_chk;
   int n_ok, n_len, n_chk, n_to;
   int lat_bad = 0, pop_bad = 0, stab_bad = 0, multi = 0;
   logic prev_valid = 1'b0, prev_stall = 1'b0, prev_last = 1'b0;
   logic [7:0] prev_data = 8'h00;
   logic busy_s = 1'b0;
   logic gap_en = 1'b0;
   int   ready_mode = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference: walk the byte stream with the frame rules, no notion of cycles.
   function automatic void model();
      int i = 0;
      int n = stim.size();
      int L;
      logic [7:0] x;
      exp_q.delete();
      e_ok = 0; e_len = 0; e_chk = 0;
      while (i < n) begin
         if (stim[i] != SOF_B) begin i++; continue; end
         i++;
         if (i >= n) break;
         L = int'(stim[i]);
         i++;
         if (L == 0 || L > MAXL) begin e_len++; continue; end
         if (i + L + 1 > n) break;
         x = 8'(L);
         for (int j = 0; j < L; j++) x = x ^ stim[i+j];
         if (x == stim[i+L]) begin
            e_ok++;
            for (int j = 0; j < L; j++) exp_q.push_back({(j == L-1), stim[i+j]});
         end else begin
            e_chk++;
         end
         i += L + 1;
      end
   endfunction

   task automatic drive_pins();
      rx_empty = (fifo.size() == 0) || (gap_en && ($urandom_range(0, 3) == 0));
      r_data   = (fifo.size() != 0) ? fifo[0] : 8'($urandom);
   endtask

   task automatic step();
      logic popped;
      @(negedge clk);
      if (frame_ok) n_ok++;
      if (err_len)  n_len++;
      if (err_chk)  n_chk++;
      if (err_to)   n_to++;
      if ((int'(frame_ok) + int'(err_len) + int'(err_chk) + int'(err_to)) > 1) multi++;
      if (frame_ok != (out_valid && !prev_valid)) lat_bad++;
      if (out_valid && rd_uart) pop_bad++;
      if (prev_stall && (!out_valid || out_data != prev_data || out_last != prev_last)) stab_bad++;
      if (out_valid && out_ready) got_q.push_back({out_last, out_data});
      prev_valid = out_valid;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      busy_s     = busy;
      popped     = rd_uart;
      @(posedge clk);
      #1;
      if (popped && fifo.size() != 0) void'(fifo.pop_front());
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'($urandom_range(0, 1));
         default: out_ready = ~out_ready;
      endcase
      drive_pins();
   endtask

   task automatic start_scn();
      stim.delete();
      got_q.delete();
      n_ok = 0; n_len = 0; n_chk = 0; n_to = 0;
   endtask

   task automatic push_stim(input int from, input int to_excl);
      for (int i = from; i < to_excl; i++) fifo.push_back(stim[i]);
      drive_pins();
   endtask

   task automatic drain(input string tag);
      int k = 0;
      do begin
         step();
         k++;
      end while (!(fifo.size() == 0 && !busy) && k < 6000);
      check_eq({tag, ":drain_bound"}, 32'(k >= 6000), 32'd0);
      step();
      step();
   endtask

   task automatic compare_scn(input string tag);
      int mism = 0;
      check_eq({tag, ":frame_ok"}, n_ok, e_ok);
      check_eq({tag, ":err_len"}, n_len, e_len);
      check_eq({tag, ":err_chk"}, n_chk, e_chk);
      check_eq({tag, ":err_to"}, n_to, 0);
      check_eq({tag, ":nbytes"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         if (got_q[i] !== exp_q[i]) mism++;
      check_eq({tag, ":payload"}, mism, 0);
   endtask

   task automatic run_scn(input string tag);
      model();
      push_stim(0, stim.size());
      drain(tag);
      compare_scn(tag);
   endtask

   task automatic add(input logic [7:0] b);
      stim.push_back(b);
   endtask

   task automatic rand_stream(input int nframes);
      logic [7:0] b, x;
      int L, kind;
      for (int f = 0; f < nframes; f++) begin
         repeat ($urandom_range(0, 3)) begin
            do b = 8'($urandom); while (b == SOF_B);
            add(b);
         end
         kind = $urandom_range(0, 7);
         add(SOF_B);
         if (kind == 7) begin
            add(($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom_range(17, 255)));
         end else begin
            L = $urandom_range(1, MAXL);
            x = 8'(L);
            add(8'(L));
            for (int j = 0; j < L; j++) begin
               b = 8'($urandom);
               add(b);
               x = x ^ b;
            end
            if (kind == 6) x = x ^ 8'($urandom_range(1, 255));
            add(x);
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int first_k;
      logic busy_before, busy_after;
      logic [7:0] x;
      reset     = 1'b0;
      out_ready = 1'b1;
      rx_empty  = 1'b1;
      r_data    = 8'h00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst:rd_uart", rd_uart, 0);
      check_eq("rst:out_valid", out_valid, 0);
      check_eq("rst:out_last", out_last, 0);
      check_eq("rst:frame_ok", frame_ok, 0);
      check_eq("rst:err_len", err_len, 0);
      check_eq("rst:err_chk", err_chk, 0);
      check_eq("rst:err_to", err_to, 0);
      check_eq("rst:busy", busy, 0);
      @(posedge clk);
      #1 reset = 1'b1;
      drive_pins();

      start_scn();
      add(8'h7E); add(8'h03); add(8'h11); add(8'h22); add(8'h33); add(8'h03);
      run_scn("basic");

      start_scn();
      add(8'h7E); add(8'h02); add(8'hAA); add(8'h55); add(8'h00);
      add(8'h7E); add(8'h01); add(8'h5A); add(8'h5B);
      run_scn("badchk");

      start_scn();
      add(8'h7E); add(8'h00); add(8'h7E); add(8'h11);
      add(8'h7E); add(8'h10);
      x = 8'h10;
      for (int j = 0; j < 16; j++) begin
         add(8'(j * 13 + 1));
         x = x ^ 8'(j * 13 + 1);
      end
      add(x);
      run_scn("badlen_max");

      ready_mode = 2;
      start_scn();
      add(8'h00); add(8'hFF); add(8'h7F);
      add(8'h7E); add(8'h02); add(8'h7E); add(8'h01); add(8'h7D);
      add(8'h7E); add(8'h01); add(8'hC3); add(8'hC2);
      run_scn("noise_bp");
      ready_mode = 0;

      // Idle exactly TIMEOUT cycles inside a frame.
      start_scn();
      fifo.push_back(8'h7E); fifo.push_back(8'h02); fifo.push_back(8'hAA);
      drive_pins();
      first_k = 0; busy_before = 1'b0; busy_after = 1'b1;
      for (int k = 0; k < 20 && fifo.size() != 0; k++) step();
      for (int k = 1; k <= TB_TO + 3; k++) begin
         step();
         if (n_to != 0 && first_k == 0) first_k = k;
         if (k == TB_TO)     busy_before = busy_s;
         if (k == TB_TO + 1) busy_after  = busy_s;
      end
      check_eq("to:cycle", first_k, TB_TO + 1);
      check_eq("to:count", n_to, 1);
      check_eq("to:busy_before", busy_before, 1);
      check_eq("to:busy_after", busy_after, 0);
      check_eq("to:frame_ok", n_ok, 0);

      // One idle cycle short of the limit: frame still completes.
      start_scn();
      add(8'h7E); add(8'h02); add(8'hAA); add(8'hBB); add(8'h13);
      model();
      push_stim(0, 3);
      for (int k = 0; k < 20 && fifo.size() != 0; k++) step();
      for (int k = 1; k <= TB_TO - 1; k++) step();
      push_stim(3, 5);
      drain("to_short");
      compare_scn("to_short");

      // Reset while DATA is half collected.
      start_scn();
      fifo.push_back(8'h7E); fifo.push_back(8'h04); fifo.push_back(8'h01);
      drive_pins();
      for (int k = 0; k < 20 && fifo.size() != 0; k++) step();
      step();
      reset = 1'b0;
      @(negedge clk);
      check_eq("rstmid:busy", busy, 0);
      check_eq("rstmid:out_valid", out_valid, 0);
      check_eq("rstmid:rd_uart", rd_uart, 0);
      check_eq("rstmid:pulses", {frame_ok, err_len, err_chk, err_to}, 0);
      @(posedge clk);
      #1 reset = 1'b1;
      n_ok = 0; n_len = 0; n_chk = 0; n_to = 0;
      repeat (8) step();
      check_eq("rstmid:after_pulses", n_ok + n_len + n_chk + n_to, 0);
      check_eq("rstmid:after_busy", busy_s, 0);

      for (int s = 0; s < 6; s++) begin
         ready_mode = s % 3;
         gap_en     = (s >= 3);
         start_scn();
         rand_stream(25);
         run_scn($sformatf("rand%0d", s));
      end
      ready_mode = 0;
      gap_en     = 1'b0;

      check_eq("latency", lat_bad, 0);
      check_eq("no_pop_in_emit", pop_bad, 0);
      check_eq("stall_stable", stab_bad, 0);
      check_eq("pulse_exclusive", multi, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
